// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display driver.
// Holds the converter FSM states, segment encodings, overflow limit.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [15:0] OVF_LIMIT = 16'd9999;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_display_driver_bin2bcd.sv
// Sequential double-dabble converter: 16-bit binary to 4 BCD digits.
// Ports: clk, reset (async, active-high), start, bin[15:0] in;
//        busy, done (DONE-state strobe), bcd[15:0], ovf (bin>9999) out.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] scr_q, scr_d;
  logic        ovf_q, ovf_d;
  logic [19:0] adj;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 5; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          ovf_d   = (bin > OVF_LIMIT);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = {adj[18:0], sr_q[15]};
        sr_d  = {sr_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bcd  = scr_q[15:0];
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_display_driver.sv
// 4-digit multiplexed 7-segment driver showing value in decimal.
// Ports: clk, reset (async, active-high), value[15:0] in;
//        an[3:0], seg[6:0], dp (all active-low), bcd_valid out.
// Build option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        bcd_valid
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          first_q, first_d;
  logic [15:0]   last_q, last_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  logic          start;
  logic          accept;
  logic          c_busy;
  logic          c_done;
  logic [15:0]   c_bcd;
  logic          c_ovf;
  logic [3:0]    dig;
  logic          lz;

  // Request a conversion on the first cycle after reset or on change.
  assign start  = first_q | (value != last_q);
  assign accept = start & ~c_busy;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (c_busy),
    .done  (c_done),
    .bcd   (c_bcd),
    .ovf   (c_ovf)
  );

  always_comb begin
    first_d = first_q;
    last_d  = last_q;
    if (accept) begin
      first_d = 1'b0;
      last_d  = value;
    end
  end

  // Display registers load atomically from the converter result.
  always_comb begin
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (c_done) begin
      disp_d  = c_bcd;
      ovf_d   = c_ovf;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // an/seg follow idx_q so every slot, including the first, lasts
  // REFRESH_DIV cycles; seg sees the next display value so the first
  // valid digit appears on the same edge bcd_valid rises.
  always_comb begin
    dig = disp_d[4*idx_q +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    unique case (idx_q)
      2'd0:    lz = 1'b0;
      2'd1:    lz = (disp_d[15:4]  == 12'd0);
      2'd2:    lz = (disp_d[15:8]  == 8'd0);
      default: lz = (disp_d[15:12] == 4'd0);
    endcase
`else
    lz = 1'b0;
`endif
    an_d = ~(4'b0001 << idx_q);
    unique case (1'b1)
      !valid_d: seg_d = SEG_BLANK;
      ovf_d:    seg_d = SEG_DASH;
      lz:       seg_d = SEG_BLANK;
      default:  seg_d = seg_encode(dig);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      first_q <= 1'b1;
      last_q  <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      first_q <= first_d;
      last_q  <= last_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign bcd_valid = valid_q;

endmodule

// File: doc/seg7_display_driver.md
SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (minimum 1).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port value  input  16  unsigned binary count to display in decimal.
REQ-005 SHALL have port an  output  4  active-low digit anodes; an[0] is the rightmost (ones) digit.
REQ-006 SHALL have port seg  output  7  active-low cathodes; seg[0]=a through seg[6]=g.
REQ-007 SHALL have port dp  output  1  active-low decimal point.
REQ-008 SHALL have port bcd_valid  output  1  high once the first conversion after reset has completed.

Function
REQ-009 SHALL convert value to 4 BCD digits with a sequential double-dabble FSM with states IDLE, SHIFT and DONE.
REQ-010 In IDLE, SHALL capture value and go to SHIFT when value differs from the last converted sample, or unconditionally on the first cycle after reset.
REQ-011 SHIFT SHALL last exactly 16 cycles, applying add-3 to each BCD nibble that is >=5 before each shift, over a 20-bit BCD scratch register.
REQ-012 DONE SHALL take 1 cycle: update the display registers atomically, set bcd_valid, then return to IDLE; latency from capture to display register update SHALL be 18 cycles.
REQ-013 Changes on value during SHIFT/DONE SHALL be ignored; the new value SHALL be picked up in the next IDLE cycle.
REQ-014 If the captured sample is >9999, DONE SHALL load the overflow flag, and all four digits SHALL show a dash (seg=7'b0111111).
REQ-015 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-016 Exactly one an bit SHALL be low at a time (an[idx]=0) once out of reset; seg SHALL be the registered encoding of digit idx and change on the same edge as an.
REQ-017 Digit encodings (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-018 dp SHALL be held at 1 (off).
REQ-019 Until bcd_valid is high, seg SHALL be blank (1111111).

Reset
REQ-020 Reset SHALL force an=4'b1111, seg=7'b1111111, dp=1 and bcd_valid=0; it SHALL clear the refresh counter, digit index, BCD/display registers and overflow flag, and put the FSM in IDLE.
REQ-021 Reset asserted mid-conversion SHALL abort it; after release, a fresh conversion of the current value SHALL start on the first clk edge.

Configuration
REQ-022 Macro SEG7_LEADING_ZERO_BLANK_EN: when defined, zero digits more significant than the highest nonzero digit SHALL show blank, digit 0 is never blanked, and overflow dashes are unaffected; when undefined, all four digits are always shown (e.g. 0042).

Structure
REQ-023 Package seg7_pkg SHALL hold the FSM state enum, the seg encoding constants (0-9, BLANK, DASH) and the overflow limit 9999.
REQ-024 The conversion FSM SHALL be sub-module bin2bcd_seq (ports clk, reset, start, bin[15:0], busy, done, bcd[15:0], ovf); the top contains refresh/mux logic only.

Verification
REQ-025 Bench uses REFRESH_DIV=4. Reset release, value=0: bcd_valid rises 18 cycles later -> digit 0 seg=1000000; digits 1-3 show 1000000 (macro off) or 1111111 (macro on).
REQ-026 value=1234 -> after 18 cycles, an=1110/1101/1011/0111 show seg 0011001/0110000/0100100/1111001, each for 4 cycles, in that rotating order.
REQ-027 value 17 -> 9999, changed at cycle 5 of SHIFT -> 17 is displayed first, then 9999 (all 0010000) 18 cycles after the next IDLE.
REQ-028 value=10000 or 65535 -> all four digits show 0111111; then value=7 -> digit 0 shows 1111000.
REQ-029 Reset pulsed during SHIFT -> outputs go to reset values immediately; after release, the current value is displayed 18 cycles later.
REQ-030 Throughout all scenarios: dp==1, the an one-hot-low invariant holds, and each digit dwells exactly REFRESH_DIV cycles.
